// File: rtl/ram_req_ctrl.sv
// Request/response front end for the data RAM: single writes, incrementing
// burst reads, with rd and wr never asserted together.
module ram_req_ctrl #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 16,
   parameter int LWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   input  logic [LWIDTH-1:0] req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_last,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_raddr,
   output logic [AWIDTH-1:0] mem_waddr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD_ISSUE,
      RD_RSP
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [LWIDTH-1:0] cnt;
   logic [LWIDTH-1:0] cnt_d;
   logic [LWIDTH-1:0] len;
   logic [LWIDTH-1:0] len_d;
   logic              rd_d;
   logic              wr_d;
   logic [AWIDTH-1:0] raddr_d;
   logic [AWIDTH-1:0] waddr_d;
   logic [DWIDTH-1:0] wdata_d;
   logic              fire_req;
   logic              fire_rsp;

   assign req_ready = ~rst & (state == IDLE);
   assign fire_req  = req_valid & req_ready;
   assign rsp_valid = (state == RD_RSP);
   assign rsp_last  = rsp_valid & (cnt == len);
   assign rsp_rdata = mem_rdata;
   assign fire_rsp  = rsp_valid & rsp_ready;
   assign busy      = (state != IDLE);

   // Strobes default low, so each rd/wr pulse lasts exactly one cycle.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      len_d   = len;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      raddr_d = mem_raddr;
      waddr_d = mem_waddr;
      wdata_d = mem_wdata;
      unique case (state)
         IDLE: begin
            if (fire_req) begin
               if (req_we) begin
                  state_d = WR;
                  wr_d    = 1'b1;
                  waddr_d = req_addr;
                  wdata_d = req_wdata;
               end else begin
                  state_d = RD_ISSUE;
                  rd_d    = 1'b1;
                  raddr_d = req_addr;
                  len_d   = req_len;
                  cnt_d   = '0;
               end
            end
         end
         WR:       state_d = IDLE;
         RD_ISSUE: state_d = RD_RSP;
         RD_RSP: begin
            if (fire_rsp) begin
               if (rsp_last) begin
                  state_d = IDLE;
               end else begin
                  state_d = RD_ISSUE;
                  rd_d    = 1'b1;
                  cnt_d   = cnt + 1'b1;
                  raddr_d = mem_raddr + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         len       <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_raddr <= '0;
         mem_waddr <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         len       <= len_d;
         mem_rd    <= rd_d;
         mem_wr    <= wr_d;
         mem_raddr <= raddr_d;
         mem_waddr <= waddr_d;
         mem_wdata <= wdata_d;
      end
   end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed and randomised checks of ram_req_ctrl against a registered-read
// RAM model and a shadow copy of its contents.
module tb_ram_req_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic [3:0]  req_len;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_last;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_raddr;
   logic [7:0]  mem_waddr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic [15:0] ram [256];
   logic [15:0] model [256];
   logic        ram_init;

   always #5 clk = ~clk;

   ram_req_ctrl #(.AWIDTH(8), .DWIDTH(16), .LWIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_last(rsp_last), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Registered-read RAM, read has priority over write
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 16'(i * 7 + 256);
      end else if (mem_rd) begin
         mem_rdata <= ram[mem_raddr];
      end else if (mem_wr) begin
         ram[mem_waddr] <= mem_wdata;
      end
   end

   task automatic issue(input logic we, input logic [7:0] a,
                        input logic [15:0] d, input logic [3:0] l);
      int t;
      req_we = we; req_addr = a; req_wdata = d; req_len = l;
      req_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL issue_timeout: req_ready=%b expected 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'b0; req_addr = 8'h55; req_wdata = 16'h5555; req_len = 4'hF;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({req_ready, mem_rd, mem_wr, rsp_valid, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_hold: rdy/rd/wr/vld/busy=%b expected 00000",
                  {req_ready, mem_rd, mem_wr, rsp_valid, busy});
      end
      @(posedge clk); #1;
      rst = 1'b0; ram_init = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || rsp_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b last=%b expected 1 0", req_ready, rsp_last);
      end
      checks++;
      if ({mem_raddr, mem_waddr, mem_wdata} !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs: got %h expected 0", {mem_raddr, mem_waddr, mem_wdata});
      end
   endtask

   task automatic test_write();
      issue(1'b1, 8'h12, 16'hBEEF, 4'h0);
      model[8'h12] = 16'hBEEF;
      @(negedge clk);
      checks++;
      if ({mem_wr, mem_rd, req_ready, busy} !== 4'b1001) begin
         errors++;
         $display("FAIL write_n1_ctl: wr/rd/rdy/busy=%b expected 1001",
                  {mem_wr, mem_rd, req_ready, busy});
      end
      checks++;
      if (mem_waddr !== 8'h12 || mem_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL write_n1_data: addr=%h data=%h expected 12 beef", mem_waddr, mem_wdata);
      end
      @(negedge clk);
      checks++;
      if ({mem_wr, req_ready, rsp_valid} !== 3'b010) begin
         errors++;
         $display("FAIL write_n2: wr/rdy/vld=%b expected 010", {mem_wr, req_ready, rsp_valid});
      end
   endtask

   task automatic test_single_read();
      rsp_ready = 1'b1;
      issue(1'b0, 8'h12, 16'h0, 4'h0);
      @(negedge clk);
      checks++;
      if ({mem_rd, mem_wr, rsp_valid} !== 3'b100 || mem_raddr !== 8'h12) begin
         errors++;
         $display("FAIL read_n1: rd/wr/vld=%b addr=%h expected 100 12",
                  {mem_rd, mem_wr, rsp_valid}, mem_raddr);
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_last, mem_rd} !== 3'b110 || rsp_rdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL read_n2: vld/last/rd=%b data=%h expected 110 beef",
                  {rsp_valid, rsp_last, mem_rd}, rsp_rdata);
      end
      @(negedge clk);
      checks++;
      if ({busy, req_ready, rsp_valid} !== 3'b010) begin
         errors++;
         $display("FAIL read_n3: busy/rdy/vld=%b expected 010", {busy, req_ready, rsp_valid});
      end
   endtask

   task automatic test_burst_wrap();
      logic [7:0] a;
      for (int i = 0; i < 4; i++) begin
         a = 8'hFE + 8'(i);
         issue(1'b1, a, 16'hA0 + 16'(i), 4'h0);
         model[a] = 16'hA0 + 16'(i);
      end
      rsp_ready = 1'b1;
      issue(1'b0, 8'hFE, 16'h0, 4'h3);
      for (int i = 0; i < 4; i++) begin
         a = 8'hFE + 8'(i);
         @(negedge clk);
         checks++;
         if ({mem_rd, rsp_valid} !== 2'b10 || mem_raddr !== a) begin
            errors++;
            $display("FAIL burst_issue%0d: rd/vld=%b addr=%h expected 10 %h",
                     i, {mem_rd, rsp_valid}, mem_raddr, a);
         end
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA0 + 16'(i) ||
             rsp_last !== (i == 3) || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL burst_beat%0d: vld=%b data=%h last=%b rd=%b expected 1 %h %b 0",
                     i, rsp_valid, rsp_rdata, rsp_last, mem_rd, 16'hA0 + 16'(i), i == 3);
         end
      end
      @(negedge clk);
      checks++;
      if ({busy, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL burst_end: busy/rdy=%b expected 01", {busy, req_ready});
      end
   endtask

   task automatic test_backpressure();
      issue(1'b1, 8'h40, 16'h1111, 4'h0);
      issue(1'b1, 8'h41, 16'h2222, 4'h0);
      issue(1'b1, 8'h42, 16'h3333, 4'h0);
      model[8'h40] = 16'h1111; model[8'h41] = 16'h2222; model[8'h42] = 16'h3333;
      rsp_ready = 1'b1;
      issue(1'b0, 8'h40, 16'h0, 4'h2);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1111) begin
         errors++;
         $display("FAIL bp_beat0: vld=%b data=%h expected 1 1111", rsp_valid, rsp_rdata);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_rd !== 1'b1 || mem_raddr !== 8'h41) begin
         errors++;
         $display("FAIL bp_issue1: rd=%b addr=%h expected 1 41", mem_rd, mem_raddr);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, rsp_last, mem_rd, mem_wr} !== 4'b1000 || rsp_rdata !== 16'h2222) begin
            errors++;
            $display("FAIL bp_hold%0d: vld/last/rd/wr=%b data=%h expected 1000 2222",
                     k, {rsp_valid, rsp_last, mem_rd, mem_wr}, rsp_rdata);
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h2222 || mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept: vld=%b data=%h rd=%b expected 1 2222 0",
                  rsp_valid, rsp_rdata, mem_rd);
      end
      @(negedge clk);
      checks++;
      if ({mem_rd, rsp_valid} !== 2'b10 || mem_raddr !== 8'h42) begin
         errors++;
         $display("FAIL bp_issue2: rd/vld=%b addr=%h expected 10 42", {mem_rd, rsp_valid}, mem_raddr);
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_last} !== 2'b11 || rsp_rdata !== 16'h3333) begin
         errors++;
         $display("FAIL bp_beat2: vld/last=%b data=%h expected 11 3333", {rsp_valid, rsp_last}, rsp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_burst();
      logic seen;
      rsp_ready = 1'b1;
      issue(1'b0, 8'h40, 16'h0, 4'h7);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_last} !== 2'b10 || rsp_rdata !== 16'h1111) begin
         errors++;
         $display("FAIL rmb_beat0: vld/last=%b data=%h expected 10 1111", {rsp_valid, rsp_last}, rsp_rdata);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rmb_rdy_in_rst: got %b expected 0", req_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_rd, mem_wr, rsp_valid, rsp_last, busy, req_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL rmb_ctl: rd/wr/vld/last/busy/rdy=%b expected 000001",
                  {mem_rd, mem_wr, rsp_valid, rsp_last, busy, req_ready});
      end
      checks++;
      if ({mem_raddr, mem_waddr, mem_wdata} !== 32'h0) begin
         errors++;
         $display("FAIL rmb_regs: got %h expected 0", {mem_raddr, mem_waddr, mem_wdata});
      end
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mem_rd || mem_wr || rsp_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rmb_quiet: activity=%b expected 0", seen);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic        we;
      logic [7:0]  a;
      logic [7:0]  ea;
      logic [15:0] d;
      logic [3:0]  l;
      int          beat;
      int          cyc;
      for (int t = 0; t < 40; t++) begin
         we = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 255));
         d  = 16'($urandom);
         l  = 4'($urandom_range(0, 3));
         issue(we, a, d, l);
         if (we) begin
            model[a] = d;
            @(negedge clk);
            checks++;
            if ({mem_wr, mem_rd} !== 2'b10 || mem_waddr !== a || mem_wdata !== d) begin
               errors++;
               $display("FAIL rnd_write%0d: wr/rd=%b addr=%h data=%h expected 10 %h %h",
                        t, {mem_wr, mem_rd}, mem_waddr, mem_wdata, a, d);
            end
         end else begin
            beat = 0;
            cyc  = 0;
            while (beat <= int'(l) && cyc < 200) begin
               rsp_ready = 1'($urandom_range(0, 1));
               @(negedge clk);
               checks++;
               if (mem_rd && mem_wr) begin
                  errors++;
                  $display("FAIL rnd_overlap%0d: rd=%b wr=%b expected not both", t, mem_rd, mem_wr);
               end
               if (rsp_valid && rsp_ready) begin
                  ea = a + 8'(beat);
                  checks++;
                  if (rsp_rdata !== model[ea] || rsp_last !== (beat == int'(l))) begin
                     errors++;
                     $display("FAIL rnd_beat%0d_%0d: data=%h last=%b expected %h %b",
                              t, beat, rsp_rdata, rsp_last, model[ea], beat == int'(l));
                  end
                  beat++;
               end
               @(posedge clk); #1;
               cyc++;
            end
            checks++;
            if (beat != int'(l) + 1) begin
               errors++;
               $display("FAIL rnd_count%0d: beats=%0d expected %0d", t, beat, int'(l) + 1);
            end
         end
      end
      rsp_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; ram_init = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 256; i++) model[i] = 16'(i * 7 + 256);
      test_reset();
      test_write();
      test_single_read();
      test_burst_wrap();
      test_backpressure();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Initiator-side controller for the single-port-style data RAM (registered read, write on clock edge). Accepts load/store requests from the pipeline over a valid/ready handshake and drives the RAM's rd/wr/address/data pins. It returns read data, including incrementing burst reads, over a valid/ready response channel. It sits between the MEM stage and the data RAM and guarantees the RAM never sees rd and wr in the same cycle.

Parameters:
AWIDTH, 8, RAM address width in bits; address space is 2^AWIDTH words.
DWIDTH, 16, RAM data word width in bits.
LWIDTH, 4, width of the burst length field; a burst carries up to 2^LWIDTH beats.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  AWIDTH  start word address.
req_wdata  in  DWIDTH  write data; ignored for reads.
req_len  in  LWIDTH  read beats minus 1; ignored for writes.
rsp_valid  out  1  read beat available.
rsp_ready  in  1  consumer accepts beat.
rsp_rdata  out  DWIDTH  read beat data.
rsp_last  out  1  final beat of the burst.
mem_rd  out  1  RAM read strobe.
mem_wr  out  1  RAM write strobe.
mem_raddr  out  AWIDTH  RAM read address.
mem_waddr  out  AWIDTH  RAM write address.
mem_wdata  out  DWIDTH  RAM write data.
mem_rdata  in  DWIDTH  RAM registered read data.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE.
  - mem_rd=0, mem_wr=0; mem_raddr, mem_waddr, mem_wdata=0.
  - Beat counter and length register =0.
  - rsp_valid=0, rsp_last=0, busy=0.
- req_ready is 0 while rst=1. Otherwise req_ready = (state==IDLE), decoded combinationally from the state register.
- All mem_* outputs are registered.
- States: IDLE, WR, RD_ISSUE, RD_RSP.
- IDLE: a handshake (req_valid & req_ready) at the edge ending cycle N:
  - req_we=1: next state WR. mem_wr, mem_waddr=req_addr and mem_wdata=req_wdata are registered.
  - req_we=0: next state RD_ISSUE. mem_rd=1, mem_raddr=req_addr; req_len is stored and the beat counter is cleared.
- WR (cycle N+1): mem_wr=1 for exactly this one cycle. Returns to IDLE, so req_ready=1 at N+2. Writes produce no response.
- RD_ISSUE: mem_rd=1 for exactly this one cycle. The RAM registers the data at the end of the cycle. Next state RD_RSP.
- RD_RSP:
  - rsp_valid=1; rsp_rdata=mem_rdata (the RAM holds its output while rd=0).
  - rsp_last = (beat counter == stored len).
  - mem_rd=0 throughout.
- RD_RSP, on rsp_valid & rsp_ready:
  - If last: go to IDLE.
  - Otherwise: increment the beat counter, set mem_raddr=mem_raddr+1 (mod 2^AWIDTH, wraps 0xFF->0x00 at AWIDTH=8), set mem_rd=1 and go to RD_ISSUE.
- Single-beat read latency: handshake at N -> rsp_valid at N+2.
- Burst throughput: one beat per 2 cycles when rsp_ready is held high.
- Backpressure: while rsp_ready=0, the controller holds rsp_valid, rsp_rdata and rsp_last stable and issues no mem_rd/mem_wr.
- Invariant: mem_rd & mem_wr is never 1 in the same cycle. The RAM gives read priority, so a simultaneous write would be lost.
- req_* inputs are sampled only on a handshake; changes while busy are ignored.
- Reset mid-operation: the operation is abandoned. No further mem_rd/mem_wr is issued and no further rsp_valid is raised. A pending WR cycle is cancelled if rst lands on the edge that would begin it. req_ready=1 in the first cycle after rst deasserts.

Test Plan:
- Write: req_we=1, addr 0x12, wdata 0xBEEF, handshake at N -> mem_wr=1, waddr=0x12, wdata=0xBEEF only at N+1; mem_rd=0; req_ready=0 at N+1, 1 at N+2.
- Single read: after the above, read 0x12 with len=0, rsp_ready=1 -> mem_rd=1 with raddr=0x12 at N+1; rsp_valid=1, rdata=0xBEEF, rsp_last=1 at N+2; IDLE at N+3.
- Wrapping burst: preload 0xFE..0x01 with 0xA0..0xA3; read 0xFE with len=3, rsp_ready=1 -> raddr sequence 0xFE, 0xFF, 0x00, 0x01; beats 0xA0..0xA3 spaced 2 cycles apart; rsp_last only on the 4th.
- Backpressure: during beat 2 of a len=2 burst, hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and rsp_last stable, mem_rd=0 throughout; the next mem_rd comes 1 cycle after acceptance.
- Reset mid-burst: assert rst for 1 cycle after beat 1 of a len=7 burst -> next cycle all outputs at reset values; no later mem_rd or rsp_valid; req_ready=1 after rst drops.
- Randomised traffic with a RAM model: assertions never see mem_rd & mem_wr together, and every accepted read returns exactly len+1 beats with data matching the model.
